// File: rtl/btn_event_queue.sv
// btn_event_queue
// Five push buttons are synchronized, debounced and turned into press events
// that are queued in a small FIFO for a ready/valid consumer.
//
// Optional build macro: BTN_EVQ_RELEASE_EN
//   defined   -> release (1->0) transitions also produce events, with ev_code[3]=1,
//                arbitrated after every pending press.
//   undefined -> only presses are queued and ev_code[3] is tied to 0.
//
// Internal button vectors are ordered like btn_level: bit4=C, bit3=L, bit2=U,
// bit1=D, bit0=R. Event button codes are 1=C, 2=L, 3=U, 4=D, 5=R.

module btn_event_queue #(
    parameter int DB_W  = 20,
    parameter int DEPTH = 4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       BtnC,
    input  logic       BtnL,
    input  logic       BtnU,
    input  logic       BtnD,
    input  logic       BtnR,
    output logic [3:0] ev_code,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [4:0] ev_count,
    output logic [4:0] btn_level,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int NBTN  = 5;
    localparam int PTR_W = $clog2(DEPTH);

`ifdef BTN_EVQ_RELEASE_EN
    // Request vector is {press[4:0], release[4:0]}; codes carry the release flag.
    localparam int CODE_W = 4;
    localparam int NREQ   = 2 * NBTN;
`else
    // Only press requests exist; the release flag is never stored.
    localparam int CODE_W = 3;
    localparam int NREQ   = NBTN;
`endif

    // Last counter value before the level is accepted: the toggle happens on
    // the (2^DB_W-1)-th consecutive clock with a differing synchronized input.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'((64'd1 << DB_W) - 64'd2);
    localparam logic [4:0]      DEPTH_C = 5'(DEPTH);

    // ------------------------------------------------------------------
    // Per-button synchronizer and debounce
    // ------------------------------------------------------------------
    logic [NBTN-1:0] raw_btn;
    logic [NBTN-1:0] level_vec;

    assign raw_btn = {BtnC, BtnL, BtnU, BtnD, BtnR};

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            logic            sync1_reg;
            logic            sync2_reg;
            logic            level_reg;
            logic [DB_W-1:0] cnt_reg;

            // Two-flop synchronizer: the raw button is asynchronous to Clk.
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                end else begin
                    sync1_reg <= raw_btn[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            // Debounce: count clocks of disagreement, flip the level when the run is long enough.
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else if (sync2_reg == level_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DB_LAST) begin
                    cnt_reg   <= '0;
                    level_reg <= ~level_reg;
                end else begin
                    cnt_reg <= cnt_reg + DB_W'(1);
                end
            end

            assign level_vec[gi] = level_reg;
        end
    endgenerate

    assign btn_level = level_vec;

    // ------------------------------------------------------------------
    // Transition detection
    // ------------------------------------------------------------------
    logic [NBTN-1:0] level_d_reg;
    logic [NBTN-1:0] rise;

    // Previous debounced level, used to find the edge one clock after it happens.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            level_d_reg <= '0;
        end else begin
            level_d_reg <= level_vec;
        end
    end

    assign rise = level_vec & ~level_d_reg;

    // ------------------------------------------------------------------
    // Pending bits and arbitration
    // ------------------------------------------------------------------
    logic [NBTN-1:0]   press_pend_reg;
    logic [NBTN-1:0]   press_pend_next;
    logic [NREQ-1:0]   req_vec;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   grant_taken;
    logic              req_found;
    logic [CODE_W-1:0] win_code;
    logic              push_en;
    logic              pop_en;
    logic              ovf_event;

    // Code stored for request index idx (highest index = highest priority).
    function automatic logic [CODE_W-1:0] req_code(input int idx);
        logic [2:0] btn;
        btn = 3'(5 - (idx % 5));
`ifdef BTN_EVQ_RELEASE_EN
        return {(idx < 5), btn};
`else
        return btn;
`endif
    endfunction

`ifdef BTN_EVQ_RELEASE_EN
    logic [NBTN-1:0] fall;
    logic [NBTN-1:0] rel_pend_reg;
    logic [NBTN-1:0] rel_pend_next;

    assign fall    = ~level_vec & level_d_reg;
    assign req_vec = {press_pend_reg, rel_pend_reg};
`else
    assign req_vec = press_pend_reg;
`endif

    // Fixed-priority pick of one pending request per clock, C first, presses before releases.
    always_comb begin
        grant     = '0;
        req_found = 1'b0;
        win_code  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_vec[i] && !req_found) begin
                req_found = 1'b1;
                grant[i]  = 1'b1;
                win_code  = req_code(i);
            end
        end
    end

    assign pop_en      = ev_valid & ev_ready;
    // A full queue still accepts a write when the head leaves in the same clock.
    assign push_en     = req_found & ((ev_count != DEPTH_C) | pop_en);
    assign grant_taken = push_en ? grant : '0;

    // Pending update: clear the winner, latch new transitions unless one is already waiting.
    always_comb begin
        press_pend_next = (press_pend_reg & ~grant_taken[NREQ-1 -: NBTN])
                        | (rise & ~press_pend_reg);
        ovf_event       = |(rise & press_pend_reg);
`ifdef BTN_EVQ_RELEASE_EN
        rel_pend_next   = (rel_pend_reg & ~grant_taken[NBTN-1:0])
                        | (fall & ~rel_pend_reg);
        ovf_event       = ovf_event | (|(fall & rel_pend_reg));
`endif
    end

    // Pending request registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            press_pend_reg <= '0;
        end else begin
            press_pend_reg <= press_pend_next;
        end
    end

`ifdef BTN_EVQ_RELEASE_EN
    // Release pending registers, only present when release events are enabled.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rel_pend_reg <= '0;
        end else begin
            rel_pend_reg <= rel_pend_next;
        end
    end
`endif

    // Sticky overflow; a fresh overflow wins over a simultaneous clear.
    logic ovf_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ovf_reg <= 1'b0;
        end else if (ovf_event) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

    assign ovf = ovf_reg;

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    logic [CODE_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [4:0]        count_reg;
    logic [4:0]        count_next;
    logic [CODE_W-1:0] head_code;

    // Storage write; contents need no reset because the head is masked when empty.
    always_ff @(posedge Clk) begin
        if (push_en) begin
            mem_reg[wr_ptr_reg] <= win_code;
        end
    end

    // Occupancy: push and pop together leave it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push_en, pop_en})
            2'b10:   count_next = count_reg + 5'd1;
            2'b01:   count_next = count_reg - 5'd1;
            default: count_next = count_reg;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    assign head_code = mem_reg[rd_ptr_reg];
    assign ev_valid  = (count_reg != 5'd0);
    assign ev_count  = count_reg;

    // Head-of-queue output, forced to zero while the queue is empty.
    always_comb begin
        ev_code = 4'h0;
        if (ev_valid) begin
`ifdef BTN_EVQ_RELEASE_EN
            ev_code = head_code;
`else
            ev_code = {1'b0, head_code};
`endif
        end
    end

endmodule
